// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants, write-channel state encoding and byte-lane merge helper
// for the AXI4-Lite register bank.
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         MAX_DW      = 64;
    localparam int         MAX_SW      = MAX_DW / 8;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_e;

    // Replace each byte of old_val whose strobe bit is set with the matching byte of new_val.
    function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_val,
                                                     input logic [MAX_DW-1:0] new_val,
                                                     input logic [MAX_SW-1:0] strb);
        logic [MAX_DW-1:0] res;
        res = old_val;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_cell.sv
// One register of the bank: normal (byte-strobed write), read-only (storage frozen)
// or write-1-to-clear with per-bit hardware set, selected by parameters.
module axi_lite_reg_cell
    import axi_lite_regbank_pkg::*;
#(
    parameter int             DW        = 32,
    parameter bit             IS_RO     = 1'b0,
    parameter bit             IS_W1C    = 1'b0,
    parameter logic [DW-1:0]  RESET_VAL = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [DW-1:0]   hw_set_i,
    output logic [DW-1:0]   q_o
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] merged;
    logic [DW-1:0] lane_mask;

    assign merged    = DW'(strb_merge(MAX_DW'(q_q), MAX_DW'(wdata_i), MAX_SW'(wstrb_i)));
    assign lane_mask = DW'(strb_merge('0, '1, MAX_SW'(wstrb_i)));

    // Hardware set is applied after the clear so a same-cycle set wins.
    always_comb begin
        q_d = q_q;
        if (IS_W1C) begin
            if (we_i) q_d = q_q & ~(wdata_i & lane_mask);
            q_d = q_d | hw_set_i;
        end else if (!IS_RO && we_i) begin
            q_d = merged;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= RESET_VAL;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank; write: 2 cycles last AW/W to BVALID,
// read: 1 cycle AR to RVALID. READY outputs are registered, never driven from VALID inputs.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_rd_data,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int IDXW     = AW - ADDR_LSB;

    wr_state_e            wstate_q;
    logic                 awready_q, wready_q, bvalid_q, rvalid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [IDXW-1:0]      aw_idx_q, commit_idx, ar_idx;
    logic [DW-1:0]        wdata_q, rdata_q, rd_val;
    logic [DW/8-1:0]      wstrb_q;
    logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS*DW-1:0] rd_flat;
    logic                 aw_hs, w_hs, ar_hs;
    logic                 unused_ok;

    assign aw_hs      = S_AXI_AWVALID && awready_q;
    assign w_hs       = S_AXI_WVALID && wready_q;
    assign ar_hs      = S_AXI_ARVALID && !rvalid_q;
    assign commit_idx = aw_hs ? S_AXI_AWADDR[AW-1:ADDR_LSB] : aw_idx_q;
    assign ar_idx     = S_AXI_ARADDR[AW-1:ADDR_LSB];

    // Out-of-range indices decode to no pulse, so nothing commits.
    always_comb begin
        wr_pulse_d = '0;
        for (int r = 0; r < NUM_REGS; r++) wr_pulse_d[r] = (int'(commit_idx) == r);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_idx_q  <= S_AXI_AWADDR[AW-1:ADDR_LSB];
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                        wready_q <= 1'b0;
                    end
                    if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                        wstate_q   <= W_COMMIT;
                        wr_pulse_q <= wr_pulse_d;
                    end
                end
                W_COMMIT: begin
                    wstate_q <= W_RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= (int'(aw_idx_q) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [DW-1:0] q;
        axi_lite_reg_cell #(
            .DW        (DW),
            .IS_RO     (RO_MASK[r]),
            .IS_W1C    (W1C_MASK[r]),
            .RESET_VAL (RESET_VALUES[r*DW +: DW])
        ) u_cell (
            .clk_i    (ACLK),
            .rst_i    (ARESET),
            .we_i     (wr_pulse_q[r]),
            .wdata_i  (wdata_q),
            .wstrb_i  (wstrb_q),
            .hw_set_i (hw_set[r*DW +: DW]),
            .q_o      (q)
        );
        assign reg_out[r*DW +: DW] = RO_MASK[r] ? '0 : q;
        assign rd_flat[r*DW +: DW] = RO_MASK[r] ? hw_rd_data[r*DW +: DW] : q;
    end

    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(ar_idx) == r) rd_val = rd_flat[r*DW +: DW];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= (int'(ar_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_pulse  = wr_pulse_q;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], hw_rd_data, hw_set};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench: instance a has plain registers (reg7 resets to DEADBEEF),
// instance b has reg2 W1C and reg5 RO; both see identical bus stimulus.
module tb_axi_lite_regbank;

    localparam logic [511:0] RV_A = {{8{32'h0}}, 32'hDEADBEEF, {7{32'h0}}};

    logic         clk, rst;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [511:0] hw_rd_data, hw_set;

    logic         awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic [1:0]   bresp_a, rresp_a;
    logic [31:0]  rdata_a;
    logic [511:0] reg_out_a;
    logic [15:0]  pulse_a;
    logic         awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]   bresp_b, rresp_b;
    logic [31:0]  rdata_b;
    logic [511:0] reg_out_b;
    logic [15:0]  pulse_b;

    int checks = 0;
    int fails  = 0;

    axi_lite_regbank #(.RESET_VALUES(RV_A)) dut_a (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_a),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
        .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
        .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready),
        .reg_out(reg_out_a), .reg_wr_pulse(pulse_a), .hw_rd_data(hw_rd_data), .hw_set(hw_set)
    );

    axi_lite_regbank #(.RO_MASK(16'h0020), .W1C_MASK(16'h0004)) dut_b (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_b),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b),
        .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
        .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready),
        .reg_out(reg_out_b), .reg_wr_pulse(pulse_b), .hw_rd_data(hw_rd_data), .hw_set(hw_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic axi_write(input int sel, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0;
        resp = 2'b11;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = 1;
        for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
            if (awvalid && awready_a) aw_done = 1;
            if (wvalid && wready_a) w_done = 1;
            @(negedge clk);
            if (aw_done) awvalid = 0;
            if (w_done) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        for (int t = 0; t < 20 && !bvalid_a; t++) @(negedge clk);
        if (!bvalid_a) begin
            fails++; checks++;
            $display("FAIL write_timeout addr=%h: no BVALID within bound", addr);
        end else begin
            resp = (sel != 0) ? bresp_b : bresp_a;
        end
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input int sel, input logic [7:0] addr,
                            output logic [31:0] data, output logic [1:0] resp);
        data = 32'hBAD0BAD0; resp = 2'b11;
        @(negedge clk);
        araddr = addr; arvalid = 1; rready = 1;
        for (int t = 0; t < 20 && !arready_a; t++) @(negedge clk);
        @(negedge clk);
        arvalid = 0;
        for (int t = 0; t < 20 && !rvalid_a; t++) @(negedge clk);
        if (!rvalid_a) begin
            fails++; checks++;
            $display("FAIL read_timeout addr=%h: no RVALID within bound", addr);
        end else begin
            data = (sel != 0) ? rdata_b : rdata_a;
            resp = (sel != 0) ? rresp_b : rresp_a;
        end
        @(negedge clk);
        rready = 0;
    endtask

    task automatic test_reset();
        checks++; if (awready_a !== 1'b1) begin fails++; $display("FAIL rst_awready: got %b want 1", awready_a); end
        checks++; if (wready_a !== 1'b1) begin fails++; $display("FAIL rst_wready: got %b want 1", wready_a); end
        checks++; if (arready_a !== 1'b1) begin fails++; $display("FAIL rst_arready: got %b want 1", arready_a); end
        checks++; if (bvalid_a !== 1'b0 || rvalid_a !== 1'b0) begin fails++; $display("FAIL rst_valids: got b=%b r=%b want 0 0", bvalid_a, rvalid_a); end
        checks++; if (rdata_a !== 32'h0 || bresp_a !== 2'b00 || rresp_a !== 2'b00) begin fails++; $display("FAIL rst_data: got rdata=%h bresp=%b rresp=%b want 0", rdata_a, bresp_a, rresp_a); end
        checks++; if (pulse_a !== 16'h0) begin fails++; $display("FAIL rst_pulse: got %h want 0", pulse_a); end
        checks++; if (reg_out_a !== RV_A) begin fails++; $display("FAIL rst_values: reg7 got %h want deadbeef", reg_out_a[7*32 +: 32]); end
    endtask

    task automatic test_legacy();
        logic [1:0] resp; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(0, 8'(i * 4), 32'(i + 1), 4'hF, resp);
            checks++; if (resp !== 2'b00) begin fails++; $display("FAIL legacy_bresp[%0d]: got %b want 00", i, resp); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(0, 8'(i * 4), d, resp);
            checks++; if (d !== 32'(i + 1) || resp !== 2'b00) begin fails++; $display("FAIL legacy_read[%0d]: got %h/%b want %h/00", i, d, resp, i + 1); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d;
        axi_write(0, 8'h00, 32'hAABBCCDD, 4'hF, resp);
        axi_write(0, 8'h00, 32'h11223344, 4'b0101, resp);
        axi_read(0, 8'h00, d, resp);
        checks++; if (d !== 32'hAA22CC44 || resp !== 2'b00) begin fails++; $display("FAIL strobe_merge: got %h/%b want aa22cc44/00", d, resp); end
    endtask

    task automatic test_w1c();
        logic [1:0] resp; logic [31:0] d;
        @(negedge clk); hw_set[2*32 +: 32] = 32'hF0;
        @(negedge clk); hw_set = '0;
        checks++; if (reg_out_b[2*32 +: 32] !== 32'hF0) begin fails++; $display("FAIL w1c_hwset: got %h want f0", reg_out_b[2*32 +: 32]); end
        axi_write(1, 8'h08, 32'h30, 4'hF, resp);
        axi_read(1, 8'h08, d, resp);
        checks++; if (d !== 32'hC0 || resp !== 2'b00) begin fails++; $display("FAIL w1c_clear: got %h/%b want c0/00", d, resp); end
        // hw_set bit4 held across the handshake and commit cycles only
        @(negedge clk);
        awaddr = 8'h08; wdata = 32'h10; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        hw_set[2*32 +: 32] = 32'h10;
        @(negedge clk); awvalid = 0; wvalid = 0;
        checks++; if (pulse_b !== 16'h0004 || bvalid_b !== 1'b0) begin fails++; $display("FAIL commit_pulse: got pulse=%h bvalid=%b want 0004 0", pulse_b, bvalid_b); end
        @(negedge clk); hw_set = '0;
        checks++; if (bvalid_b !== 1'b1) begin fails++; $display("FAIL bvalid_latency: got %b want 1 two cycles after AW/W", bvalid_b); end
        bready = 1;
        @(negedge clk); bready = 0;
        checks++; if (reg_out_b[2*32 +: 32] !== 32'hD0) begin fails++; $display("FAIL w1c_set_wins: got %h want d0", reg_out_b[2*32 +: 32]); end
    endtask

    task automatic test_ro();
        logic [1:0] resp; logic [31:0] d;
        axi_write(1, 8'h14, 32'h12345678, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin fails++; $display("FAIL ro_bresp: got %b want 00", resp); end
        axi_read(1, 8'h14, d, resp);
        checks++; if (d !== 32'h5A5A0005 || resp !== 2'b00) begin fails++; $display("FAIL ro_read: got %h/%b want 5a5a0005/00", d, resp); end
        checks++; if (reg_out_b[5*32 +: 32] !== 32'h0) begin fails++; $display("FAIL ro_reg_out: got %h want 0", reg_out_b[5*32 +: 32]); end
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [31:0] d; logic [511:0] exp_regs;
        exp_regs = RV_A;
        exp_regs[0*32 +: 32] = 32'hAA22CC44;
        exp_regs[1*32 +: 32] = 32'h2;
        exp_regs[2*32 +: 32] = 32'h10;
        exp_regs[3*32 +: 32] = 32'h4;
        exp_regs[5*32 +: 32] = 32'h12345678;
        axi_write(0, 8'h40, 32'hFFFFFFFF, 4'hF, resp);
        checks++; if (resp !== 2'b10) begin fails++; $display("FAIL oor_bresp: got %b want 10", resp); end
        checks++; if (reg_out_a !== exp_regs) begin fails++; $display("FAIL oor_no_change: reg0 got %h want aa22cc44", reg_out_a[31:0]); end
        axi_read(0, 8'h40, d, resp);
        checks++; if (d !== 32'h0 || resp !== 2'b10) begin fails++; $display("FAIL oor_read: got %h/%b want 0/10", d, resp); end
        axi_read(0, 8'h3C, d, resp);
        checks++; if (d !== 32'h0 || resp !== 2'b00) begin fails++; $display("FAIL last_reg_read: got %h/%b want 0/00", d, resp); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] d;
        int pulses = 0, hold = 0;
        @(negedge clk); wdata = 32'h77; wstrb = 4'hF; wvalid = 1; bready = 0;
        @(negedge clk); wvalid = 0;
        checks++; if (wready_a !== 1'b0 || awready_a !== 1'b1) begin fails++; $display("FAIL w_first_ready: got w=%b aw=%b want 0 1", wready_a, awready_a); end
        @(negedge clk);
        @(negedge clk); awaddr = 8'h0C; awvalid = 1;
        @(negedge clk); awvalid = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += $countones(pulse_a);
            if (i >= 1 && bvalid_a === 1'b1 && bresp_a === 2'b00) hold++;
            if (i == 5) bready = 1;
            @(negedge clk);
        end
        pulses += $countones(pulse_a);
        bready = 0;
        checks++; if (pulses != 1) begin fails++; $display("FAIL single_pulse: got %0d pulse cycles want 1", pulses); end
        checks++; if (hold != 5) begin fails++; $display("FAIL bvalid_hold: got %0d cycles want 5", hold); end
        checks++; if (bvalid_a !== 1'b0 || awready_a !== 1'b1 || wready_a !== 1'b1) begin fails++; $display("FAIL b_release: got bvalid=%b aw=%b w=%b want 0 1 1", bvalid_a, awready_a, wready_a); end
        axi_read(0, 8'h0C, d, resp);
        checks++; if (d !== 32'h77) begin fails++; $display("FAIL w_first_data: got %h want 77", d); end
    endtask

    task automatic test_reset_inflight();
        logic [1:0] resp; logic [31:0] d;
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        araddr = 8'h00; arvalid = 1; rready = 0;
        @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        checks++; if (bvalid_a !== 1'b1 || rvalid_a !== 1'b1) begin fails++; $display("FAIL inflight_setup: got b=%b r=%b want 1 1", bvalid_a, rvalid_a); end
        #2 rst = 1;
        #1;
        checks++; if (bvalid_a !== 1'b0 || rvalid_a !== 1'b0) begin fails++; $display("FAIL async_drop: got b=%b r=%b want 0 0", bvalid_a, rvalid_a); end
        checks++; if (reg_out_a !== RV_A) begin fails++; $display("FAIL async_values: reg1 got %h want 0, reg7 got %h want deadbeef", reg_out_a[63:32], reg_out_a[7*32 +: 32]); end
        @(negedge clk); rst = 0;
        axi_write(0, 8'h04, 32'h55, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin fails++; $display("FAIL post_rst_bresp: got %b want 00", resp); end
        axi_read(0, 8'h04, d, resp);
        checks++; if (d !== 32'h55) begin fails++; $display("FAIL post_rst_read: got %h want 55", d); end
    endtask

    initial begin
        rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0; hw_set = '0; hw_rd_data = '0;
        hw_rd_data[5*32 +: 32] = 32'h5A5A0005;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 0;
        test_legacy();
        test_strobe();
        test_w1c();
        test_ro();
        test_slverr();
        test_w_before_aw();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It succeeds the fixed four-register controller slave and sits behind the AXI interconnect in the controller block design.
- Adds a configurable register count and data width, byte strobes, and per-register read-only and write-1-to-clear types.
- Adds hardware event inputs and error responses for out-of-range addresses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64
C_S_AXI_ADDR_WIDTH, 8, byte address width; must satisfy NUM_REGS*(DW/8) <= 2**AW
NUM_REGS, 16, number of registers, 1..64
RO_MASK, all 0, bit r=1: register r is read-only, read value comes from hw_rd_data
W1C_MASK, all 0, bit r=1: register r is write-1-to-clear with hardware set
RESET_VALUES, all 0, NUM_REGS*DW flat vector of reset values; register r uses slice [r*DW +: DW]

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  AW  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DW  write data
S_AXI_WSTRB  in  DW/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AW  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*DW  current register contents; RO slices read 0
reg_wr_pulse  out  NUM_REGS  one-cycle strobe on each committed write to a register
hw_rd_data  in  NUM_REGS*DW  source data for RO registers
hw_set  in  NUM_REGS*DW  per-bit event set inputs for W1C registers

Behaviour:
- Reset (async on ARESET high): registers load RESET_VALUES. AWREADY, WREADY and ARREADY go to 1. BVALID, RVALID, BRESP, RRESP, RDATA and reg_wr_pulse go to 0. Any in-flight transaction is discarded.
- Register index = AWADDR/ARADDR[AW-1:log2(DW/8)]. The low byte-offset bits are ignored.
- Write channel FSM:
  - W_IDLE: AW and W are accepted independently. Each handshake captures its payload and drops the matching READY.
  - When both are held, the write commits in the next cycle (W_COMMIT) and the FSM enters W_RESP.
  - W_RESP: BVALID held until BREADY. AWREADY and WREADY are then reasserted in the following cycle.
  - AW and W arriving in the same cycle commit one cycle later. Latency from the last of AW/W to BVALID is 2 cycles.
- Commit rules, applied per byte lane where WSTRB=1:
  - Normal register: lane replaced by WDATA.
  - W1C register: bits where WDATA=1 are cleared.
  - RO register: no change; response is still OKAY.
  - reg_wr_pulse[r] fires for the commit cycle whenever the index is in range, including RO registers and WSTRB=0.
- W1C hardware set: every cycle, reg |= hw_set slice. When set and clear hit the same bit in the same cycle, set wins.
- Index >= NUM_REGS: write is ignored with BRESP=SLVERR (2'b10); read returns RDATA=0 with RRESP=SLVERR. Otherwise responses are OKAY (2'b00).
- Read channel:
  - ARREADY=1 when RVALID=0.
  - After the AR handshake, RDATA and RVALID register on the next edge (1-cycle latency). RDATA/RVALID then hold until RREADY, and ARREADY returns once RVALID clears.
  - Read of an RO register samples hw_rd_data at the AR handshake cycle.
- Read and write channels are independent. A read of register r in the same cycle as a commit to r returns the pre-commit value.
- Back-to-back throughput: one write per 3 cycles and one read per 2 cycles, with READY/VALID held at 1.
- No combinational path from any VALID input to any READY output.

Decomposition:
- Package axi_lite_regbank_pkg: RESP_OKAY/RESP_SLVERR constants, write FSM state enum, and a function for byte-strobe merging.
- One sub-module, axi_lite_reg_cell, per register. It holds the storage and implements normal/RO/W1C commit plus hw_set, selected by parameters. Instantiate it with a generate loop.

Test Plan:
- Reset, then write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC and read them back -> each read equals the written value, all RESP=OKAY. This reproduces the legacy four-register test.
- Write 0xAABBCCDD to reg0, then write 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44.
- Reg2 W1C with reset value 0: pulse hw_set=0x0000_00F0 for one cycle, then write 0x30 -> read 0xC0. Same-cycle hw_set bit4 and W1C clear of bit4 -> bit4 remains 1.
- Access with NUM_REGS=16 at address 0x40 -> write BRESP=SLVERR with no register changed; read RDATA=0 with RRESP=SLVERR.
- Present W three cycles before AW, and hold BREADY=0 for 5 cycles -> single commit, reg_wr_pulse asserted for exactly 1 cycle, BVALID held stable for 5 cycles.
- Assert ARESET while BVALID=1 and RVALID=1 -> both drop asynchronously, registers return to RESET_VALUES, and the next write completes normally.
